// File: rtl/env_update_scheduler.sv
// Schedules the environment-update engine every FRAME_DIV frame ticks and re-times its vertex stream through a FWFT FIFO.
// Optional cycle statistics port enabled by defining ENV_SCHED_STATS_EN.
module env_update_scheduler #(
    parameter int unsigned WORLD_BITS     = 32,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned FRAME_DIV      = 1,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  frame_tick_in,
    input  logic                  pause_in,
    input  logic                  clr_flags_in,
    output logic                  env_start_out,
    input  logic                  env_valid_in,
    input  logic [WORLD_BITS-1:0] env_x_in,
    input  logic [WORLD_BITS-1:0] env_y_in,
    input  logic                  env_done_in,
    output logic                  pt_valid_out,
    input  logic                  pt_ready_in,
    output logic [WORLD_BITS-1:0] pt_x_out,
    output logic [WORLD_BITS-1:0] pt_y_out,
    output logic                  busy_out,
    output logic                  frame_done_out,
    output logic [15:0]           point_count_out,
    output logic                  overflow_out,
    output logic                  timeout_out,
    output logic [7:0]            dropped_ticks_out
`ifdef ENV_SCHED_STATS_EN
    ,
    output logic [15:0]           last_cycles_out
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, START, RUN, DRAIN, DONE} state_t;

    state_t                state, next;
    logic [DW-1:0]         div;
    logic [TW-1:0]         wd;
    logic [15:0]           cnt;
    logic [WORLD_BITS-1:0] mem_x [FIFO_DEPTH];
    logic [WORLD_BITS-1:0] mem_y [FIFO_DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr;
    logic                  empty, full, pop, push_req, push;
    logic                  tick_go, wd_hit;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = !empty && pt_ready_in;
    assign push_req = (state == RUN) && env_valid_in;
    // A pop in the same cycle frees a slot, so a push onto a full FIFO still lands.
    assign push     = push_req && (!full || pop);

    assign tick_go = (state == IDLE) && frame_tick_in && !pause_in && (div == DW'(FRAME_DIV - 1));
    assign wd_hit  = (state == RUN) && (wd == TW'(TIMEOUT_CYCLES - 1));

    assign pt_valid_out   = !empty;
    assign pt_x_out       = empty ? '0 : mem_x[rd_ptr[AW-1:0]];
    assign pt_y_out       = empty ? '0 : mem_y[rd_ptr[AW-1:0]];
    assign busy_out       = (state != IDLE);
    assign frame_done_out = (state == DONE);

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (tick_go) next = START;
            START:   next = RUN;
            RUN:     if (env_done_in || wd_hit) next = DRAIN;
            DRAIN:   if (empty) next = DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_x[wr_ptr[AW-1:0]] <= env_x_in;
            mem_y[wr_ptr[AW-1:0]] <= env_y_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state             <= IDLE;
            env_start_out     <= 1'b0;
            div               <= '0;
            wd                <= '0;
            cnt               <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            point_count_out   <= '0;
            overflow_out      <= 1'b0;
            timeout_out       <= 1'b0;
            dropped_ticks_out <= '0;
        end else begin
            state <= next;
            // Start pulse is registered off START, so it lines up with the first RUN cycle.
            env_start_out <= (state == START);

            if ((state == IDLE) && frame_tick_in && !pause_in)
                div <= tick_go ? '0 : div + 1'b1;

            if (state == START) begin
                cnt <= '0;
                wd  <= '0;
            end else if (state == RUN) begin
                wd <= wd + 1'b1;
                if (push && (cnt != 16'hFFFF))
                    cnt <= cnt + 1'b1;
            end

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            if (state == DONE)
                point_count_out <= cnt;

            if (clr_flags_in) begin
                overflow_out <= 1'b0;
                timeout_out  <= 1'b0;
            end
            if (push_req && full && !pop)
                overflow_out <= 1'b1;
            if (wd_hit)
                timeout_out <= 1'b1;

            if (frame_tick_in && (state != IDLE))
                dropped_ticks_out <= clr_flags_in ? 8'd1 :
                                     (dropped_ticks_out == 8'hFF) ? dropped_ticks_out :
                                     dropped_ticks_out + 1'b1;
            else if (clr_flags_in)
                dropped_ticks_out <= '0;
        end
    end

`ifdef ENV_SCHED_STATS_EN
    logic [15:0] cyc;

    // cyc counts START itself, so at DONE it covers START through the last DRAIN cycle.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cyc             <= '0;
            last_cycles_out <= '0;
        end else begin
            if (state == START)
                cyc <= 16'd1;
            else if (((state == RUN) || (state == DRAIN)) && (cyc != 16'hFFFF))
                cyc <= cyc + 1'b1;
            if (state == DONE)
                last_cycles_out <= cyc;
        end
    end
`endif

endmodule
